// File: rtl/vc_test_arb_pkg.sv
// Shared types and the round-robin search helper for the test-stream arbiters.
// The helper works on a fixed 16-bit request vector so that any requester count up to 16 can reuse it.
package vc_test_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int unsigned c_max_nreqs = 16;

    // First set bit of req at or after ptr, wrapping at n; returns n when no bit in [0,n) is set.
    function automatic int unsigned rr_search(
        input logic [c_max_nreqs-1:0] req,
        input int unsigned            ptr,
        input int unsigned            n
    );
        int unsigned k;
        logic        found;
        rr_search = n;
        found     = 1'b0;
        for (int unsigned i = 32'd0; i < c_max_nreqs; i++) begin
            k = ptr + i;
            if (k >= n) begin
                k = k - n;
            end else begin
                k = k;
            end
            if (!found && (i < n) && req[k[3:0]]) begin
                found     = 1'b1;
                rr_search = k;
            end else begin
                found = found;
            end
        end
    endfunction

endpackage

// File: rtl/vc_test_rr_pick.sv
// Combinational round-robin picker: finds the first asserted request starting at ptr.
// idx is only meaningful while any is high.
module vc_test_rr_pick
    import vc_test_arb_pkg::*;
#(
    parameter  int p_nreqs     = 4,
    localparam int c_src_nbits = $clog2(p_nreqs)
) (
    input  logic [p_nreqs-1:0]      req,
    input  logic [c_src_nbits-1:0]  ptr,
    output logic                    any,
    output logic [c_src_nbits-1:0]  idx
);

    logic [c_max_nreqs-1:0] req_pad_s;
    int unsigned            pick_s;

    assign req_pad_s = c_max_nreqs'(req);
    assign pick_s    = rr_search(req_pad_s, 32'(ptr), 32'(p_nreqs));
    assign any       = (pick_s != 32'(p_nreqs));
    assign idx       = c_src_nbits'(pick_s);

endmodule

// File: rtl/vc_test_stream_arb.sv
// Round-robin val/rdy arbiter merging p_nreqs streams onto one sink through a one-entry
// registered output stage, with an optional burst lock that keeps the grant on one requester.
module vc_test_stream_arb
    import vc_test_arb_pkg::*;
#(
    parameter  int p_nreqs     = 4,
    parameter  int p_msg_nbits = 8,
    parameter  int p_max_burst = 1,
    localparam int c_src_nbits = $clog2(p_nreqs)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [p_nreqs-1:0]             in_val,
    output logic [p_nreqs-1:0]             in_rdy,
    input  logic [p_nreqs*p_msg_nbits-1:0] in_msg,
    output logic                           out_val,
    input  logic                           out_rdy,
    output logic [p_msg_nbits-1:0]         out_msg,
    output logic [c_src_nbits-1:0]         out_src
);

    localparam int                      c_burst_nbits = $clog2(p_max_burst + 1);
    localparam logic [c_burst_nbits-1:0] c_max_burst  = c_burst_nbits'(p_max_burst);
    localparam logic [c_burst_nbits-1:0] c_burst_one  = c_burst_nbits'(1);
    localparam logic [c_src_nbits-1:0]   c_last_src   = c_src_nbits'(p_nreqs - 1);

    arb_state_e               state_r, state_s;
    logic [c_src_nbits-1:0]   owner_r, owner_s;
    logic [c_src_nbits-1:0]   ptr_r, ptr_s;
    logic [c_burst_nbits-1:0] burst_cnt_r, burst_cnt_s;
    logic                     out_val_r;
    logic [p_msg_nbits-1:0]   out_msg_r;
    logic [c_src_nbits-1:0]   out_src_r;

    logic                     pick_any_s;
    logic [c_src_nbits-1:0]   pick_idx_s;
    logic                     hold_s;
    logic                     grant_vld_s;
    logic [c_src_nbits-1:0]   grant_s;
    logic                     buf_en_s;
    logic                     xfer_s;
    logic [p_nreqs-1:0]       in_rdy_s;
    logic [p_msg_nbits-1:0]   sel_msg_s;

    function automatic logic [c_src_nbits-1:0] wrap_inc(input logic [c_src_nbits-1:0] s);
        return (s == c_last_src) ? {c_src_nbits{1'b0}} : s + c_src_nbits'(1);
    endfunction

    vc_test_rr_pick #(
        .p_nreqs (p_nreqs)
    ) u_pick (
        .req (in_val),
        .ptr (ptr_r),
        .any (pick_any_s),
        .idx (pick_idx_s)
    );

    assign hold_s   = (state_r == LOCKED) && in_val[owner_r] && (burst_cnt_r < c_max_burst);
    assign buf_en_s = !out_val_r || out_rdy;
    // Gating with reset_n keeps every in_rdy low for the whole time reset is asserted.
    assign xfer_s   = reset_n && buf_en_s && grant_vld_s;

    // Grant selection: a live lock wins, otherwise round-robin from ptr.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_s     = {c_src_nbits{1'b0}};
        if (hold_s) begin
            grant_vld_s = 1'b1;
            grant_s     = owner_r;
        end else begin
            grant_vld_s = pick_any_s;
            grant_s     = pick_idx_s;
        end
    end

    // One-hot ready decode and message mux for the granted requester.
    always_comb begin
        in_rdy_s  = {p_nreqs{1'b0}};
        sel_msg_s = {p_msg_nbits{1'b0}};
        if (xfer_s) begin
            in_rdy_s[grant_s] = 1'b1;
        end else begin
            in_rdy_s = {p_nreqs{1'b0}};
        end
        for (int i = 0; i < p_nreqs; i++) begin
            if (grant_s == c_src_nbits'(i)) begin
                sel_msg_s = in_msg[i*p_msg_nbits +: p_msg_nbits];
            end else begin
                sel_msg_s = sel_msg_s;
            end
        end
    end

    // Arbitration FSM next state; a lock survives a stalled sink as long as the owner stays valid.
    always_comb begin
        state_s     = state_r;
        owner_s     = owner_r;
        ptr_s       = ptr_r;
        burst_cnt_s = burst_cnt_r;
        if (hold_s) begin
            if (xfer_s && (burst_cnt_r == c_max_burst - c_burst_one)) begin
                state_s     = IDLE;
                ptr_s       = wrap_inc(owner_r);
                burst_cnt_s = {c_burst_nbits{1'b0}};
            end else if (xfer_s) begin
                burst_cnt_s = burst_cnt_r + c_burst_one;
            end else begin
                state_s = state_r;
            end
        end else if (xfer_s) begin
            ptr_s = wrap_inc(grant_s);
            if (p_max_burst > 1) begin
                state_s     = LOCKED;
                owner_s     = grant_s;
                burst_cnt_s = c_burst_one;
            end else begin
                state_s     = IDLE;
                burst_cnt_s = {c_burst_nbits{1'b0}};
            end
        end else if (state_r == LOCKED) begin
            state_s     = IDLE;
            ptr_s       = wrap_inc(owner_r);
            burst_cnt_s = {c_burst_nbits{1'b0}};
        end else begin
            state_s = IDLE;
        end
    end

    // FSM, owner, pointer and burst counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            owner_r     <= {c_src_nbits{1'b0}};
            ptr_r       <= {c_src_nbits{1'b0}};
            burst_cnt_r <= {c_burst_nbits{1'b0}};
        end else begin
            state_r     <= state_s;
            owner_r     <= owner_s;
            ptr_r       <= ptr_s;
            burst_cnt_r <= burst_cnt_s;
        end
    end

    // Output buffer: replaced on an input transfer, emptied by an output-only transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_val_r <= 1'b0;
            out_msg_r <= {p_msg_nbits{1'b0}};
            out_src_r <= {c_src_nbits{1'b0}};
        end else if (xfer_s) begin
            out_val_r <= 1'b1;
            out_msg_r <= sel_msg_s;
            out_src_r <= grant_s;
        end else if (out_rdy) begin
            out_val_r <= 1'b0;
        end else begin
            out_val_r <= out_val_r;
        end
    end

    assign in_rdy  = in_rdy_s;
    assign out_val = out_val_r;
    assign out_msg = out_msg_r;
    assign out_src = out_src_r;

endmodule

// File: tb/tb_vc_test_stream_arb.sv
// Directed bench for vc_test_stream_arb: one pure round-robin instance and one burst-locked
// instance (p_max_burst=3), followed by a random-delay multi-source system run.
module tb_vc_test_stream_arb;

    logic        clk = 1'b0;
    logic        reset_n;

    logic [3:0]  in_val_a, in_rdy_a;
    logic [31:0] in_msg_a;
    logic        out_val_a, out_rdy_a;
    logic [7:0]  out_msg_a;
    logic [1:0]  out_src_a;

    logic [3:0]  in_val_b, in_rdy_b;
    logic [31:0] in_msg_b;
    logic        out_val_b, out_rdy_b;
    logic [7:0]  out_msg_b;
    logic [1:0]  out_src_b;

    int n_vec;
    int n_err;

    always #5 clk = ~clk;

    vc_test_stream_arb #(.p_nreqs(4), .p_msg_nbits(8), .p_max_burst(1)) u_rr (
        .clk(clk), .reset_n(reset_n),
        .in_val(in_val_a), .in_rdy(in_rdy_a), .in_msg(in_msg_a),
        .out_val(out_val_a), .out_rdy(out_rdy_a), .out_msg(out_msg_a), .out_src(out_src_a)
    );

    vc_test_stream_arb #(.p_nreqs(4), .p_msg_nbits(8), .p_max_burst(3)) u_bl (
        .clk(clk), .reset_n(reset_n),
        .in_val(in_val_b), .in_rdy(in_rdy_b), .in_msg(in_msg_b),
        .out_val(out_val_b), .out_rdy(out_rdy_b), .out_msg(out_msg_b), .out_src(out_src_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          bl_src [7];
        logic [3:0]  bl_rdy [7];
        logic [3:0]  vb;
        logic [3:0]  acc;
        int          sent [4];
        int          rcv [4];
        int          total;
        int          cyc;

        bl_src = '{0, 0, 0, 2, 2, 2, 0};
        bl_rdy = '{4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0001};
        n_vec = 0;
        n_err = 0;

        // Reset with every requester valid.
        reset_n   = 1'b0;
        in_val_a  = 4'b1111;
        in_msg_a  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        out_rdy_a = 1'b0;
        in_val_b  = 4'b1111;
        in_msg_b  = {8'h13, 8'h12, 8'h11, 8'h10};
        out_rdy_b = 1'b0;
        tick();
        chk("rst_rdy_a", in_rdy_a, 4'b0000);
        chk("rst_val_a", out_val_a, 1'b0);
        chk("rst_src_a", out_src_a, 2'd0);
        chk("rst_msg_a", out_msg_a, 8'h00);
        chk("rst_rdy_b", in_rdy_b, 4'b0000);
        chk("rst_val_b", out_val_b, 1'b0);
        out_rdy_a = 1'b1;
        tick();
        chk("rst_hold_rdy_a", in_rdy_a, 4'b0000);

        // Pure round-robin: 0,1,2,3,0,1 at one transfer per cycle.
        reset_n   = 1'b1;
        in_val_b  = 4'b0000;
        out_rdy_b = 1'b1;
        #1;
        chk("rr_first_rdy", in_rdy_a, 4'b0001);
        chk("bl_idle_rdy", in_rdy_b, 4'b0000);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rr_val", out_val_a, 1'b1);
            chk("rr_src", out_src_a, 32'(k % 4));
            chk("rr_msg", out_msg_a, 32'(8'hA0 + (k % 4)));
            chk("rr_next_rdy", in_rdy_a, 32'(4'b0001 << ((k + 1) % 4)));
        end
        // Freeze the round-robin instance holding src1/A1 with ptr at 2.
        out_rdy_a = 1'b0;

        // Burst lock: in_val=0101 gives 0,0,0,2,2,2,0.
        in_val_b = 4'b0101;
        #1;
        chk("bl_first_rdy", in_rdy_b, 4'b0001);
        chk("rr_stall_rdy", in_rdy_a, 4'b0000);
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("bl_src", out_src_b, 32'(bl_src[k]));
            chk("bl_msg", out_msg_b, 32'(8'h10 + bl_src[k]));
            chk("bl_next_rdy", in_rdy_b, 32'(bl_rdy[k]));
        end

        // Owner drops after one transfer of a fresh burst: grant moves to 2 at once.
        in_val_b = 4'b0100;
        in_msg_b[23:16] = 8'h5C;
        #1;
        chk("bl_drop_rdy", in_rdy_b, 4'b0100);
        tick();
        chk("bl_drop_src", out_src_b, 2'd2);
        chk("bl_drop_msg", out_msg_b, 8'h5C);

        // Backpressure with the lock held by requester 2.
        out_rdy_b = 1'b0;
        in_val_b  = 4'b0101;
        in_msg_b[23:16] = 8'h5D;
        #1;
        chk("bp_rdy0", in_rdy_b, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_val", out_val_b, 1'b1);
            chk("bp_msg", out_msg_b, 8'h5C);
            chk("bp_src", out_src_b, 2'd2);
            chk("bp_rdy", in_rdy_b, 4'b0000);
        end
        out_rdy_b = 1'b1;
        #1;
        chk("bp_lock_kept", in_rdy_b, 4'b0100);
        tick();
        chk("bp_res1_msg", out_msg_b, 8'h5D);
        chk("bp_res1_rdy", in_rdy_b, 4'b0100);
        tick();
        chk("bp_res2_src", out_src_b, 2'd2);
        chk("bp_res2_rdy", in_rdy_b, 4'b0001);
        tick();
        chk("bp_res3_src", out_src_b, 2'd0);
        chk("bp_res3_msg", out_msg_b, 8'h10);

        // Asynchronous reset between clock edges discards the buffered message.
        #3;
        chk("ar_pre_val", out_val_a, 1'b1);
        chk("ar_pre_src", out_src_a, 2'd1);
        reset_n = 1'b0;
        #1;
        chk("ar_val_a", out_val_a, 1'b0);
        chk("ar_val_b", out_val_b, 1'b0);
        chk("ar_rdy_a", in_rdy_a, 4'b0000);
        chk("ar_rdy_b", in_rdy_b, 4'b0000);
        tick();
        tick();
        chk("ar_hold_rdy_a", in_rdy_a, 4'b0000);
        reset_n   = 1'b1;
        out_rdy_a = 1'b1;
        in_val_b  = 4'b0000;
        #1;
        chk("ar_restart_rdy", in_rdy_a, 4'b0001);
        tick();
        chk("ar_first_src", out_src_a, 2'd0);
        chk("ar_first_msg", out_msg_a, 8'hA0);
        tick();
        chk("ar_second_src", out_src_a, 2'd1);
        in_val_a = 4'b0000;
        tick();
        chk("out_only_drain", out_val_a, 1'b0);

        // Random-delay system: 4 sources x 32 tagged messages into a random-ready sink.
        vb    = 4'b0000;
        total = 0;
        cyc   = 0;
        for (int i = 0; i < 4; i++) begin
            sent[i] = 0;
            rcv[i]  = 0;
        end
        while (total < 128 && cyc < 5000) begin
            for (int i = 0; i < 4; i++) begin
                if (!vb[i] && sent[i] < 32 && $urandom_range(0, 1) == 0) begin
                    vb[i] = 1'b1;
                    in_msg_b[i*8 +: 8] = {2'(i), 6'(sent[i])};
                end
            end
            in_val_b  = vb;
            out_rdy_b = ($urandom_range(0, 3) != 0);
            #1;
            chk("sys_rdy_onehot",
                32'(($countones(in_rdy_b) <= 1) && ((in_rdy_b & ~in_val_b) == 4'b0000)), 32'd1);
            acc = in_val_b & in_rdy_b;
            if (out_val_b && out_rdy_b) begin
                chk("sys_msg", out_msg_b, {out_src_b, 6'(rcv[out_src_b])});
                rcv[out_src_b]++;
                total++;
            end
            tick();
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    vb[i] = 1'b0;
                    sent[i]++;
                end
            end
            cyc++;
        end
        chk("sys_total", total, 32'd128);
        for (int i = 0; i < 4; i++) begin
            chk("sys_per_src", rcv[i], 32'd32);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vc_test_stream_arb.md
Name: vc_test_stream_arb

Overview:
- Round-robin val/rdy arbiter that merges p_nreqs test-source streams onto one shared sink port.
- Used in test harnesses where several random-delay sources drive a single random-delay sink.
- Optional burst lock lets the current winner keep the grant for up to p_max_burst back-to-back transfers.
- A registered one-entry output stage gives 1-cycle latency at full throughput.

Parameters:
- p_nreqs, 4, number of requester streams (2..16).
- p_msg_nbits, 8, message width per stream.
- p_max_burst, 1, max consecutive transfers granted to one requester while it stays valid (1 = pure round-robin).
- c_src_nbits (local), $clog2(p_nreqs), width of requester index.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_val  in  p_nreqs  per-requester valid.
- in_rdy  out  p_nreqs  per-requester ready; at most one bit high in any cycle.
- in_msg  in  p_nreqs*p_msg_nbits  requester i occupies bits [i*p_msg_nbits +: p_msg_nbits].
- out_val  out  1  output valid (registered).
- out_rdy  in  1  sink ready.
- out_msg  out  p_msg_nbits  output message (registered).
- out_src  out  c_src_nbits  index of the requester that produced out_msg (registered).

Behaviour:
- Reset (reset_n low, async): out_val=0, out_msg=0, out_src=0, priority pointer ptr=0, burst_cnt=0, state=IDLE. All in_rdy are 0 while reset_n is low.
- Output stage: buf_en = !out_val || out_rdy.
  - Output transfer occurs when out_val && out_rdy.
  - out_msg and out_src hold stable while out_val && !out_rdy.
- Grant (combinational, per cycle):
  - LOCKED state with in_val[owner]=1 and burst_cnt<p_max_burst: grant=owner.
  - Otherwise grant is the first i with in_val[i]=1, searching ptr, ptr+1, ... mod p_nreqs.
  - No valid input: no grant.
- in_rdy[i] = buf_en && granted && grant==i. in_rdy never depends on out_msg contents.
- Input transfer on in_val[g] && in_rdy[g]:
  - Next cycle: out_val=1, out_msg=in_msg[g], out_src=g.
- Out-only transfer (no input transfer in the same cycle): out_val goes to 0 next cycle.
- Simultaneous output and input transfers in one cycle: the buffer is replaced. This sustains 1 transfer/cycle.
- FSM:
  - IDLE, on input transfer from g:
    - p_max_burst>1: go to LOCKED, owner=g, burst_cnt=1.
    - p_max_burst=1: stay IDLE, ptr=(g+1) mod p_nreqs.
  - LOCKED, on input transfer from owner: burst_cnt++.
    - If burst_cnt reaches p_max_burst: go to IDLE, ptr=(owner+1) mod p_nreqs, burst_cnt=0.
  - LOCKED, cycle with in_val[owner]=0 and no transfer: go to IDLE, ptr=(owner+1) mod p_nreqs, burst_cnt=0.
    - A different requester may win arbitration in that same cycle; it starts a fresh burst (LOCKED, burst_cnt=1, or IDLE if p_max_burst=1).
  - LOCKED with in_val[owner]=1 but buf_en=0 (sink stalled): hold state; the lock is not lost on backpressure.
- Wrap-around: ptr wraps from p_nreqs-1 to 0. burst_cnt is c_burst_nbits wide and never exceeds p_max_burst.
- Fairness: with every in_val held high and out_rdy=1, each requester gets exactly p_max_burst consecutive grants in index order.
- Reset mid-operation: a buffered message is discarded (out_val=0 immediately). No in_rdy is asserted until after reset_n rises.
- Pure val/rdy protocol: sources must hold msg stable while val && !rdy. The arbiter never drops or duplicates a message.
- Trace: line shows per-input val/rdy state and "src:msg" of the output.

Decomposition:
- Shared package vc_test_arb_pkg:
  - state encoding (IDLE=1'b0, LOCKED=1'b1)
  - helper for the rotate-and-priority-encode round-robin search.
- One natural sub-module: vc_test_rr_pick.
  - Combinational round-robin picker.
  - Inputs: req vector, ptr. Outputs: any, idx.
  - Reused by later multi-port sinks.
- Top module holds the FSM, burst counter, ptr and output register.

Test Plan:
- Reset and idle: reset_n=0 with in_val=4'b1111 -> in_rdy=0, out_val=0. One cycle after reset_n=1 with out_rdy=1 -> out_src=0.
- Round-robin, p_max_burst=1: in_val=4'b1111, out_rdy=1, msgs 8'hA0..A3 held -> out_src sequence 0,1,2,3,0,...; one output per cycle after 1-cycle latency.
- Burst lock, p_max_burst=3: in_val=4'b0101 continuous -> out_src 0,0,0,2,2,2,0,...
  - Drop in_val[0] after 1 transfer -> grant moves to 2 the same cycle.
- Backpressure: out_rdy=0 for 5 cycles while out_val=1, out_msg=8'h5C -> out_msg/out_src stable, all in_rdy=0, lock retained; resumes in order on out_rdy=1.
- Random-delay system: 4 vc_TestRandDelaySources (src max_delay 3), each sending 32 messages tagged {id,seq}, into one vc_TestRandDelaySink (max_delay 10) -> all 128 arrive, per-source order preserved, done within 5000 cycles.
- Async reset mid-stream: pull reset_n low between clock edges while out_val=1 -> out_val drops immediately; after release, arbitration restarts at ptr=0 with no duplicate delivery of the discarded message.
